// File: rtl/bram_rd_pkg.sv
// Shared types and constants for the BRAM burst reader and its output buffer.
package bram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/fifo2.sv
// Two-entry first-word-fall-through buffer; push and pop may occur in the same cycle.
module fifo2
    import bram_rd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;

    // Entries are cleared on reset so nothing stale can ever reach the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                entry[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= din;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign dout = entry[rd_ptr];

endmodule

// File: rtl/bram_burst_reader.sv
// Reads a burst of consecutive words from one port of a BRAM and streams them out
// through a 2-entry buffer with valid/ready handshaking.
module bram_burst_reader
    import bram_rd_pkg::*;
#(
    parameter int DATA = 15,
    parameter int ADDR = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [ADDR-1:0] base_addr,
    input  logic [ADDR:0]   len,
    output logic [ADDR-1:0] ram_addr,
    output logic            ram_wr,
    input  logic [DATA-1:0] ram_dout,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DATA-1:0] m_data,
    output logic            m_last,
    output logic            busy,
    output logic            done
);

    state_t        state;
    state_t        state_next;
    logic [ADDR:0] reads_left;
    logic [ADDR:0] pushes_left;
    logic          inflight;
    logic [1:0]    fifo_count;
    logic [2:0]    credit;
    logic          start_ok;
    logic          issue;
    logic          last_read;
    logic          pop;
    logic          push;
    logic [DATA:0] fifo_din;
    logic [DATA:0] fifo_head;

    assign start_ok  = (state == IDLE) && start && (len != '0);
    assign pop       = m_valid && m_ready;
    assign push      = inflight;

    // Words already buffered plus the one still in the RAM pipeline, less the one
    // leaving now, must leave room for the read issued this cycle.
    assign credit    = {1'b0, fifo_count} + 3'(inflight) - 3'(pop);
    assign issue     = (state == RUN) && (credit < 3'(FIFO_DEPTH));
    assign last_read = issue && (reads_left == (ADDR+1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = RUN;
            RUN:     if (last_read) state_next = DRAIN;
            DRAIN:   if (pop && m_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr    <= '0;
            reads_left  <= '0;
            pushes_left <= '0;
            inflight    <= 1'b0;
            done        <= 1'b0;
        end else begin
            inflight <= issue;
            done     <= (state == DRAIN) && pop && m_last;
            if (start_ok) begin
                ram_addr    <= base_addr;
                reads_left  <= len;
                pushes_left <= len;
            end else begin
                if (issue) begin
                    ram_addr   <= ram_addr + ADDR'(1);
                    reads_left <= reads_left - (ADDR+1)'(1);
                end
                if (push) begin
                    pushes_left <= pushes_left - (ADDR+1)'(1);
                end
            end
        end
    end

    // The last flag travels with its word so the head of the buffer alone decides m_last.
    assign fifo_din = {(pushes_left == (ADDR+1)'(1)), ram_dout};

    fifo2 #(
        .WIDTH (DATA + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_head),
        .count (fifo_count)
    );

    assign m_valid = (fifo_count != 2'd0);
    assign m_data  = fifo_head[DATA-1:0];
    assign m_last  = m_valid && fifo_head[DATA];
    assign busy    = (state != IDLE);
    assign ram_wr  = 1'b0;

endmodule

// File: tb/tb_bram_burst_reader.sv
// Scoreboard bench for bram_burst_reader driving a true-dual-port RAM preloaded with mem[i]=i.
module tb_bram_burst_reader;
    import bram_rd_pkg::*;

    localparam int DATA  = 15;
    localparam int ADDR  = 6;
    localparam int DEPTH = 1 << ADDR;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [ADDR-1:0] base_addr;
    logic [ADDR:0]   len;
    logic [ADDR-1:0] ram_addr;
    logic            ram_wr;
    logic [DATA-1:0] ram_dout;
    logic            m_valid;
    logic            m_ready;
    logic [DATA-1:0] m_data;
    logic            m_last;
    logic            busy;
    logic            done;

    logic            b_we;
    logic [ADDR-1:0] b_addr;
    logic [DATA-1:0] b_din;
    logic [DATA-1:0] mem [DEPTH];

    int checks_total  = 0;
    int checks_passed = 0;
    int cyc           = 0;
    int start_cyc     = 0;
    int done_cyc      = 0;
    int done_count    = 0;
    int beats_seen    = 0;
    bit lat_armed     = 0;
    bit hold_valid    = 0;
    logic [DATA-1:0] hold_data;
    logic            hold_last;
    logic [DATA:0]   exp_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Port A serves the reader, port B preloads; both ports share clk.
    always @(posedge clk) begin
        if (b_we) mem[b_addr] <= b_din;
        if (ram_wr) mem[ram_addr] <= '0;
        ram_dout <= mem[ram_addr];
    end

    bram_burst_reader #(
        .DATA (DATA),
        .ADDR (ADDR)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .ram_addr  (ram_addr),
        .ram_wr    (ram_wr),
        .ram_dout  (ram_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Issues a burst request and queues the words the preloaded RAM must return.
    task automatic applyStimulus(input int base, input int length);
        start     = 1'b1;
        base_addr = ADDR'(base);
        len       = (ADDR+1)'(length);
        start_cyc = cyc;
        lat_armed = 1'b1;
        for (int k = 0; k < length; k++) begin
            exp_q.push_back({(k == length - 1), DATA'((base + k) % DEPTH)});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulseStart(input int base, input int length);
        start     = 1'b1;
        base_addr = ADDR'(base);
        len       = (ADDR+1)'(length);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns just after the negedge of the done cycle, still inside it.
    task automatic waitDone(input string name, input int exp_cycles);
        int d0;
        int n;
        d0 = done_count;
        n  = 0;
        while (done_count == d0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_count == d0) begin
            checks_total++;
            $display("[TB] FAIL %s_timeout: actual=no done expected=done within 400 cycles", name);
        end else begin
            checkOutput({name, "_busy_at_done"}, busy, 0);
            if (exp_cycles >= 0) checkOutput({name, "_done_cycle"}, done_cyc - start_cyc, exp_cycles);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stall stability and latency.
    always @(negedge clk) begin
        if (rst_n) begin
            if (lat_armed && m_valid) begin
                lat_armed = 1'b0;
                checkOutput("first_beat_latency", cyc - start_cyc, 3);
            end
            if (hold_valid) begin
                hold_valid = 1'b0;
                checkOutput("stall_stable", {m_valid, m_last, m_data}, {1'b1, hold_last, hold_data});
            end
            if (m_valid && m_ready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    checks_total++;
                    $display("[TB] FAIL unexpected_beat: actual=%0h expected=no beat", m_data);
                end else begin
                    checkOutput("beat", {m_last, m_data}, exp_q.pop_front());
                end
            end else if (m_valid) begin
                hold_valid = 1'b1;
                hold_data  = m_data;
                hold_last  = m_last;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        int any;
        int d0;
        int b0;
        int n;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        m_ready   = 1'b1;
        b_we      = 1'b0;
        b_addr    = '0;
        b_din     = '0;
        #1;
        checkOutput("reset_outputs", {m_valid, m_last, busy, done, ram_wr, ram_addr}, 0);

        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk);
            #1;
            b_we   = 1'b1;
            b_addr = ADDR'(i);
            b_din  = DATA'(i);
        end
        @(posedge clk);
        #1;
        b_we  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] burst base=4 len=8");
        applyStimulus(4, 8);
        waitDone("b4", 11);
        @(negedge clk);
        #1;
        checkOutput("done_one_cycle", done, 0);

        $display("[TB] burst base=60 len=8 with wrap");
        @(posedge clk);
        #1;
        applyStimulus(60, 8);
        waitDone("wrap", 11);

        $display("[TB] burst len=5 with stalls");
        @(posedge clk);
        #1;
        d0 = done_count;
        applyStimulus(20, 5);
        n = 0;
        while (done_count == d0 && n < 200) begin
            m_ready = (n % 3 == 0);
            @(posedge clk);
            #1;
            checkOutput("fifo_occupancy", (u_dut.fifo_count <= 2'(FIFO_DEPTH)), 1);
            n++;
        end
        m_ready = 1'b1;
        checkOutput("stall_done_seen", done_count - d0, 1);
        checkOutput("stall_queue_empty", exp_q.size(), 0);

        $display("[TB] len=0 start and start while busy");
        @(posedge clk);
        #1;
        d0 = done_count;
        pulseStart(7, 0);
        any = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            any = any | busy | m_valid | done;
        end
        checkOutput("len0_no_activity", any, 0);
        checkOutput("len0_no_done", done_count - d0, 0);
        @(posedge clk);
        #1;
        applyStimulus(10, 6);
        @(posedge clk);
        #1;
        pulseStart(40, 3);
        waitDone("busy_start", -1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
        end
        checkOutput("busy_start_idle", busy, 0);
        checkOutput("busy_start_queue", exp_q.size(), 0);

        $display("[TB] reset mid-burst");
        @(posedge clk);
        #1;
        b0 = beats_seen;
        applyStimulus(30, 10);
        n = 0;
        while (beats_seen < b0 + 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("beats_before_reset", beats_seen - b0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midburst_reset_outputs",
                    {m_valid, m_last, busy, done, ram_wr, ram_addr, u_dut.inflight, u_dut.fifo_count}, 0);
        checkOutput("midburst_reset_state", u_dut.state, IDLE);
        exp_q.delete();
        hold_valid = 1'b0;
        lat_armed  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(0, 2);
        waitDone("post_reset", 5);

        $display("[TB] full-depth burst then back-to-back start");
        @(posedge clk);
        #1;
        applyStimulus(0, 64);
        waitDone("full", 67);
        applyStimulus(5, 4);
        waitDone("back_to_back", 7);
        repeat (4) @(negedge clk);
        checkOutput("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/bram_burst_reader.md
BRAM_BURST_READER -- requirements
Module: bram_burst_reader

Interface
REQ-001 Parameter DATA, default 15, RAM word width in bits.
REQ-002 Parameter ADDR, default 6, RAM address width in bits; RAM depth is 2**ADDR.
REQ-003 clk  in  1  single clock; all logic rises on posedge clk.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 start  in  1  burst request, sampled only in IDLE.
REQ-006 base_addr  in  ADDR  first word address of the burst.
REQ-007 len  in  ADDR+1  burst length in words, legal range 1..2**ADDR.
REQ-008 ram_addr  out  ADDR  read address to one port of the dual-port RAM.
REQ-009 ram_wr  out  1  write enable to the same RAM port, held 0.
REQ-010 ram_dout  in  DATA  RAM read data, valid one clock after ram_addr.
REQ-011 m_valid  out  1  output beat valid.
REQ-012 m_ready  in  1  downstream accepts the beat.
REQ-013 m_data  out  DATA  output word.
REQ-014 m_last  out  1  marks the final beat of the burst.
REQ-015 busy  out  1  burst in progress.
REQ-016 done  out  1  one-cycle pulse at burst completion.

Function
REQ-017 States: IDLE, RUN, DRAIN.
REQ-018 IDLE->RUN when start=1 and len!=0; base_addr and len are registered on that edge.
REQ-019 start with len=0 is ignored: no beats, no done, remains IDLE.
REQ-020 start while busy=1 is ignored.
REQ-021 RUN issues one read per cycle when (fifo_count + inflight - pop) < 2, where pop = m_valid and m_ready in the current cycle.
REQ-022 Read address starts at base_addr and increments by 1 per issued read, wrapping from 2**ADDR-1 to 0.
REQ-023 inflight is a registered flag set on the cycle a read is issued; when it is 1, ram_dout is written into the FIFO on the next edge.
REQ-024 Output FIFO depth is 2; it never overflows; beats leave in address order.
REQ-025 Latency: start in cycle 0 -> ram_addr=base_addr in cycle 1 -> FIFO write at the end of cycle 2 -> m_valid=1 in cycle 3.
REQ-026 Throughput: with m_ready held at 1, one beat per cycle, no bubbles after the first beat.
REQ-027 RUN->DRAIN once len reads have been issued; DRAIN->IDLE on the handshake of the last beat.
REQ-028 m_last=1 only while the beat numbered len is presented.
REQ-029 done=1 for exactly the cycle after the last-beat handshake, and busy=0 in that same cycle.
REQ-030 A new start is accepted in the done cycle, so bursts can run back to back.
REQ-031 m_valid, once high, stays high and m_data and m_last stay stable until the handshake completes.
REQ-032 ram_addr holds its last value when no read is issued.
REQ-033 len=2**ADDR reads every word exactly once, including the wrap.

Reset
REQ-034 Asserting rst_n low immediately forces state=IDLE, m_valid=0, m_last=0, busy=0, done=0, ram_addr=0, ram_wr=0, inflight=0, and fifo_count=0, including mid-burst.
REQ-035 After reset is released, the first start behaves as in REQ-025; no stale FIFO or in-flight data ever appears.

Structure
REQ-036 Package bram_rd_pkg holds the state enum (IDLE, RUN, DRAIN) and the constant FIFO_DEPTH=2.
REQ-037 The 2-entry output buffer is sub-module fifo2 (DATA-wide plus the last bit, push/pop, count output); the credit logic stays in bram_burst_reader.
REQ-038 The bench connects the block to a dual-clock true-dual-port RAM with both clocks tied to clk; port B preloads mem[i]=i.

Verification
REQ-039 base_addr=4, len=8, m_ready=1 -> beats 4..11 on 8 consecutive cycles starting 3 cycles after start; m_last on the beat 11; done one cycle later.
REQ-040 base_addr=60, len=8, ADDR=6 -> data 60,61,62,63,0,1,2,3 in order; m_last on the beat 3.
REQ-041 len=5, m_ready toggling 1,0,0,1,... -> exactly 5 beats, no loss or duplication, m_data stable while stalled, no more than 2 entries held.
REQ-042 len=0 start -> busy stays 0, no m_valid, no done; start during a burst -> ignored, burst completes unchanged.
REQ-043 rst_n pulsed low after the 3rd beat of len=10 -> all outputs 0 immediately; a following start with base_addr=0, len=2 yields exactly beats 0,1.
REQ-044 len=64 with back-to-back start in the done cycle -> 64 beats 0..63, then a second burst with no gap beyond the REQ-025 latency.
